// File: rtl/itch_msg_parser.sv
// itch_msg_parser: strips the MoldUDP64 header from each UDP payload and walks the
// length-prefixed ITCH 5.0 messages, emitting Add / Delete / Execute strobes with
// decoded big-endian fields one cycle after the message's last byte.
module itch_msg_parser #(
    parameter int unsigned HDR_BYTES = 20,
    parameter int unsigned ADD_LEN   = 36,
    parameter int unsigned DEL_LEN   = 19,
    parameter int unsigned EXEC_LEN  = 31
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic [7:0]  data,
    input  logic        dataValid,
    input  logic        packetLost,
    output logic        addValid,
    output logic [15:0] addLocate,
    output logic [63:0] addRefNum,
    output logic        addBuySell,
    output logic [31:0] addShares,
    output logic [31:0] addPrice,
    output logic        delValid,
    output logic [15:0] delLocate,
    output logic [63:0] delRefNum,
    output logic        execValid,
    output logic [15:0] execLocate,
    output logic [63:0] execRefNum,
    output logic [15:0] msgDropCnt
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HDR    = 3'd1;
    localparam logic [2:0] S_LEN_HI = 3'd2;
    localparam logic [2:0] S_LEN_LO = 3'd3;
    localparam logic [2:0] S_BODY   = 3'd4;
    localparam logic [2:0] S_DROP   = 3'd5;

    localparam logic [7:0] TYPE_ADD  = 8'h41;
    localparam logic [7:0] TYPE_DEL  = 8'h44;
    localparam logic [7:0] TYPE_EXEC = 8'h45;
    localparam logic [7:0] SIDE_BUY  = 8'h42;

    logic [2:0]  r_state;
    logic [15:0] r_cnt;
    logic [15:0] r_len;
    logic [7:0]  r_type;
    logic        r_armed;
    logic [15:0] r_sh_loc;
    logic [63:0] r_sh_ref;
    logic        r_sh_bs;
    logic [31:0] r_sh_shares;
    logic [31:0] r_sh_price;

    logic [2:0]  w_state_nxt;
    logic [15:0] w_cnt_nxt;
    logic [15:0] w_len_nxt;
    logic [7:0]  w_type_nxt;
    logic [15:0] w_loc_nxt;
    logic [63:0] w_ref_nxt;
    logic        w_bs_nxt;
    logic [31:0] w_shares_nxt;
    logic [31:0] w_price_nxt;
    logic        w_fire_add;
    logic        w_fire_del;
    logic        w_fire_exec;
    logic        w_drop;
    logic [7:0]  w_cur_type;
    logic [15:0] w_len_full;
    logic        w_partial;

    // Next-state, field capture and completion decode for the accepted byte
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_len_nxt    = r_len;
        w_type_nxt   = r_type;
        w_loc_nxt    = r_sh_loc;
        w_ref_nxt    = r_sh_ref;
        w_bs_nxt     = r_sh_bs;
        w_shares_nxt = r_sh_shares;
        w_price_nxt  = r_sh_price;
        w_fire_add   = 1'b0;
        w_fire_del   = 1'b0;
        w_fire_exec  = 1'b0;
        w_drop       = 1'b0;
        w_cur_type   = (r_cnt == 16'd0) ? data : r_type;
        w_len_full   = {r_len[15:8], data};
        // A message counts as started once its type byte has been accepted
        w_partial    = (r_state == S_BODY) && (r_cnt != 16'd0) &&
                       ((r_type == TYPE_ADD) || (r_type == TYPE_DEL) || (r_type == TYPE_EXEC));

        if (packetLost) begin
            w_drop      = w_partial;
            w_state_nxt = dataValid ? S_DROP : S_IDLE;
        end else if (!dataValid) begin
            w_drop      = w_partial;
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_armed) begin
                        if (HDR_BYTES <= 1) begin
                            w_state_nxt = S_LEN_HI;
                        end else begin
                            w_state_nxt = S_HDR;
                            w_cnt_nxt   = 16'd1;
                        end
                    end
                end
                S_HDR: begin
                    if (r_cnt == 16'(HDR_BYTES - 1)) begin
                        w_state_nxt = S_LEN_HI;
                    end else begin
                        w_cnt_nxt = r_cnt + 16'd1;
                    end
                end
                S_LEN_HI: begin
                    w_len_nxt   = {data, 8'h00};
                    w_state_nxt = S_LEN_LO;
                end
                S_LEN_LO: begin
                    w_len_nxt = w_len_full;
                    if (w_len_full == 16'd0) begin
                        w_state_nxt = S_LEN_HI;
                    end else begin
                        w_state_nxt = S_BODY;
                        w_cnt_nxt   = 16'd0;
                    end
                end
                S_BODY: begin
                    w_type_nxt = w_cur_type;
                    if ((r_cnt == 16'd1) || (r_cnt == 16'd2)) begin
                        w_loc_nxt = {r_sh_loc[7:0], data};
                    end
                    if ((r_cnt >= 16'd11) && (r_cnt <= 16'd18)) begin
                        w_ref_nxt = {r_sh_ref[55:0], data};
                    end
                    if (w_cur_type == TYPE_ADD) begin
                        if (r_cnt == 16'd19) begin
                            w_bs_nxt = (data == SIDE_BUY);
                        end
                        if ((r_cnt >= 16'd20) && (r_cnt <= 16'd23)) begin
                            w_shares_nxt = {r_sh_shares[23:0], data};
                        end
                        if ((r_cnt >= 16'd32) && (r_cnt <= 16'd35)) begin
                            w_price_nxt = {r_sh_price[23:0], data};
                        end
                    end
                    if (r_cnt == r_len - 16'd1) begin
                        w_state_nxt = S_LEN_HI;
                        w_cnt_nxt   = 16'd0;
                        if (w_cur_type == TYPE_ADD) begin
                            w_fire_add = (r_len == 16'(ADD_LEN));
                            w_drop     = (r_len != 16'(ADD_LEN));
                        end else if (w_cur_type == TYPE_DEL) begin
                            w_fire_del = (r_len == 16'(DEL_LEN));
                            w_drop     = (r_len != 16'(DEL_LEN));
                        end else if (w_cur_type == TYPE_EXEC) begin
                            w_fire_exec = (r_len == 16'(EXEC_LEN));
                            w_drop      = (r_len != 16'(EXEC_LEN));
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 16'd1;
                    end
                end
                S_DROP: begin
                    w_state_nxt = S_DROP;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State, shadow fields and parser bookkeeping
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_state     <= S_IDLE;
            r_cnt       <= 16'd0;
            r_len       <= 16'd0;
            r_type      <= 8'd0;
            // A reset taken mid-packet must not resume parsing that packet
            r_armed     <= !dataValid;
            r_sh_loc    <= 16'd0;
            r_sh_ref    <= 64'd0;
            r_sh_bs     <= 1'b0;
            r_sh_shares <= 32'd0;
            r_sh_price  <= 32'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_len       <= w_len_nxt;
            r_type      <= w_type_nxt;
            r_armed     <= r_armed | !dataValid;
            r_sh_loc    <= w_loc_nxt;
            r_sh_ref    <= w_ref_nxt;
            r_sh_bs     <= w_bs_nxt;
            r_sh_shares <= w_shares_nxt;
            r_sh_price  <= w_price_nxt;
        end
    end

    // Output strobes, held field groups and saturating drop counter
    always_ff @(posedge clk) begin
        if (!rstN) begin
            addValid   <= 1'b0;
            addLocate  <= 16'd0;
            addRefNum  <= 64'd0;
            addBuySell <= 1'b0;
            addShares  <= 32'd0;
            addPrice   <= 32'd0;
            delValid   <= 1'b0;
            delLocate  <= 16'd0;
            delRefNum  <= 64'd0;
            execValid  <= 1'b0;
            execLocate <= 16'd0;
            execRefNum <= 64'd0;
            msgDropCnt <= 16'd0;
        end else begin
            addValid  <= w_fire_add;
            delValid  <= w_fire_del;
            execValid <= w_fire_exec;
            if (w_fire_add) begin
                addLocate  <= w_loc_nxt;
                addRefNum  <= w_ref_nxt;
                addBuySell <= w_bs_nxt;
                addShares  <= w_shares_nxt;
                addPrice   <= w_price_nxt;
            end
            if (w_fire_del) begin
                delLocate <= w_loc_nxt;
                delRefNum <= w_ref_nxt;
            end
            if (w_fire_exec) begin
                execLocate <= w_loc_nxt;
                execRefNum <= w_ref_nxt;
            end
            if (w_drop && (msgDropCnt != 16'hFFFF)) begin
                msgDropCnt <= msgDropCnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_itch_msg_parser.sv
// tb_itch_msg_parser: directed and randomized packets checked against a
// message-level model of the MoldUDP64/ITCH walk.
module tb_itch_msg_parser;

    typedef struct {
        int          idx;
        int          kind;
        logic [15:0] loc;
        logic [63:0] rf;
        logic        bs;
        logic [31:0] sh;
        logic [31:0] pr;
    } ev_t;

    logic        clk = 1'b0;
    logic        rstN;
    logic [7:0]  data;
    logic        dataValid;
    logic        packetLost;
    logic        addValid;
    logic [15:0] addLocate;
    logic [63:0] addRefNum;
    logic        addBuySell;
    logic [31:0] addShares;
    logic [31:0] addPrice;
    logic        delValid;
    logic [15:0] delLocate;
    logic [63:0] delRefNum;
    logic        execValid;
    logic [15:0] execLocate;
    logic [63:0] execRefNum;
    logic [15:0] msgDropCnt;

    int   tests = 0;
    int   fails = 0;
    int   exp_drop = 0;
    logic [7:0] pkt[$];
    ev_t  evq[$];

    always #5 clk = ~clk;

    itch_msg_parser dut (
        .clk(clk), .rstN(rstN), .data(data), .dataValid(dataValid), .packetLost(packetLost),
        .addValid(addValid), .addLocate(addLocate), .addRefNum(addRefNum),
        .addBuySell(addBuySell), .addShares(addShares), .addPrice(addPrice),
        .delValid(delValid), .delLocate(delLocate), .delRefNum(delRefNum),
        .execValid(execValid), .execLocate(execLocate), .execRefNum(execRefNum),
        .msgDropCnt(msgDropCnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic bit is_ade(input logic [7:0] t);
        return (t == 8'h41) || (t == 8'h44) || (t == 8'h45);
    endfunction

    function automatic logic [63:0] be(input int s, input int nb);
        logic [63:0] v = 64'd0;
        for (int k = 0; k < nb; k++) v = {v[55:0], pkt[s + k]};
        return v;
    endfunction

    task automatic add_hdr();
        for (int k = 0; k < 20; k++) pkt.push_back(8'($urandom));
    endtask

    task automatic add_msg(input logic [7:0] t, input int len, input logic [15:0] loc,
                           input logic [63:0] rf, input logic bs, input logic [31:0] sh,
                           input logic [31:0] pr);
        logic [15:0] l16;
        logic [7:0]  b;
        l16 = 16'(len);
        pkt.push_back(l16[15:8]);
        pkt.push_back(l16[7:0]);
        for (int k = 0; k < len; k++) begin
            b = 8'($urandom);
            if (k == 0) b = t;
            else if (k >= 1 && k <= 2) b = loc[8*(2-k) +: 8];
            else if (k >= 11 && k <= 18) b = rf[8*(18-k) +: 8];
            else if (k == 19) b = bs ? 8'h42 : 8'h53;
            else if (k >= 20 && k <= 23) b = sh[8*(23-k) +: 8];
            else if (k >= 32 && k <= 35) b = pr[8*(35-k) +: 8];
            pkt.push_back(b);
        end
    endtask

    // Walks the first n accepted bytes of pkt message by message
    task automatic model(input int n);
        int p;
        int len;
        logic [7:0] t;
        ev_t e;
        p = 20;
        while (p + 2 <= n) begin
            len = int'({pkt[p], pkt[p + 1]});
            p += 2;
            if (len == 0) continue;
            if (p + len > n) begin
                if (p < n && is_ade(pkt[p])) exp_drop++;
                break;
            end
            t = pkt[p];
            e.idx = p + len - 1;
            e.kind = 0;
            if (t == 8'h41 && len == 36) e.kind = 1;
            else if (t == 8'h44 && len == 19) e.kind = 2;
            else if (t == 8'h45 && len == 31) e.kind = 3;
            else if (is_ade(t)) exp_drop++;
            if (e.kind != 0) begin
                e.loc = 16'(be(p + 1, 2));
                e.rf  = be(p + 11, 8);
                e.bs  = (e.kind == 1) ? (pkt[p + 19] == 8'h42) : 1'b0;
                e.sh  = (e.kind == 1) ? 32'(be(p + 20, 4)) : 32'd0;
                e.pr  = (e.kind == 1) ? 32'(be(p + 32, 4)) : 32'd0;
                evq.push_back(e);
            end
            p += len;
        end
    endtask

    task automatic check_cycle(input int i);
        int  kind;
        ev_t e;
        kind = 0;
        if (evq.size() > 0 && evq[0].idx == i) begin
            e = evq.pop_front();
            kind = e.kind;
        end
        chk("add_valid", 64'(addValid), 64'(kind == 1));
        chk("del_valid", 64'(delValid), 64'(kind == 2));
        chk("exec_valid", 64'(execValid), 64'(kind == 3));
        if (kind == 1) begin
            chk("add_locate", 64'(addLocate), 64'(e.loc));
            chk("add_ref", addRefNum, e.rf);
            chk("add_bs", 64'(addBuySell), 64'(e.bs));
            chk("add_shares", 64'(addShares), 64'(e.sh));
            chk("add_price", 64'(addPrice), 64'(e.pr));
        end else if (kind == 2) begin
            chk("del_locate", 64'(delLocate), 64'(e.loc));
            chk("del_ref", delRefNum, e.rf);
        end else if (kind == 3) begin
            chk("exec_locate", 64'(execLocate), 64'(e.loc));
            chk("exec_ref", execRefNum, e.rf);
        end
    endtask

    task automatic drive(input logic [7:0] d, input logic v, input logic l);
        @(negedge clk);
        data = d;
        dataValid = v;
        packetLost = l;
        @(posedge clk);
        #1;
    endtask

    // cut: bytes driven (-1 = all); lost: byte index carrying packetLost (-1 = none)
    task automatic send_packet(input int cut, input int lost);
        int n;
        int drive_n;
        n = pkt.size();
        drive_n = (cut >= 0) ? cut : n;
        model((lost >= 0) ? lost : drive_n);
        for (int i = 0; i < drive_n; i++) begin
            drive(pkt[i], 1'b1, 1'(i == lost));
            check_cycle(i);
        end
        drive(8'h00, 1'b0, 1'b0);
        check_cycle(-1);
        chk("drop_cnt", 64'(msgDropCnt), 64'(exp_drop));
        chk("events_left", 64'(evq.size()), 64'd0);
        evq.delete();
        pkt.delete();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_addValid"}, 64'(addValid), 64'd0);
        chk({tag, "_addLocate"}, 64'(addLocate), 64'd0);
        chk({tag, "_addRefNum"}, addRefNum, 64'd0);
        chk({tag, "_addBuySell"}, 64'(addBuySell), 64'd0);
        chk({tag, "_addShares"}, 64'(addShares), 64'd0);
        chk({tag, "_addPrice"}, 64'(addPrice), 64'd0);
        chk({tag, "_delValid"}, 64'(delValid), 64'd0);
        chk({tag, "_delLocate"}, 64'(delLocate), 64'd0);
        chk({tag, "_delRefNum"}, delRefNum, 64'd0);
        chk({tag, "_execValid"}, 64'(execValid), 64'd0);
        chk({tag, "_execLocate"}, 64'(execLocate), 64'd0);
        chk({tag, "_execRefNum"}, execRefNum, 64'd0);
        chk({tag, "_msgDropCnt"}, 64'(msgDropCnt), 64'd0);
    endtask

    initial begin
        int r;
        int nm;
        int len;
        int cut;
        int lost;
        logic [7:0] t;

        rstN = 1'b0;
        data = 8'h00;
        dataValid = 1'b0;
        packetLost = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rstN = 1'b1;

        // Add order, exact fields
        add_hdr();
        add_msg(8'h41, 36, 16'h0005, 64'h1234, 1'b1, 32'd100, 32'h0001_86A0);
        send_packet(-1, -1);

        // Delete then Execute back-to-back in one packet
        add_hdr();
        add_msg(8'h44, 19, 16'h0003, 64'hAA, 1'b0, 32'd0, 32'd0);
        add_msg(8'h45, 31, 16'h0007, 64'hBB, 1'b0, 32'd0, 32'd0);
        send_packet(-1, -1);

        // System event skipped, delete decodes, no drop
        add_hdr();
        add_msg(8'h53, 12, 16'h0000, 64'h0, 1'b0, 32'd0, 32'd0);
        add_msg(8'h44, 19, 16'h0011, 64'hDEAD_BEEF_0000_0001, 1'b0, 32'd0, 32'd0);
        send_packet(-1, -1);

        // Wrong-length add drops, following delete still parses
        add_hdr();
        add_msg(8'h41, 35, 16'h0009, 64'h55, 1'b0, 32'd7, 32'd8);
        add_msg(8'h44, 19, 16'h0012, 64'h66, 1'b0, 32'd0, 32'd0);
        send_packet(-1, -1);

        // dataValid falls at add offset 20, next packet's delete is fine
        add_hdr();
        add_msg(8'h41, 36, 16'h0001, 64'h77, 1'b1, 32'd5, 32'd6);
        send_packet(42, -1);
        add_hdr();
        add_msg(8'h44, 19, 16'h0013, 64'h88, 1'b0, 32'd0, 32'd0);
        send_packet(-1, -1);

        // packetLost mid-execute, rest of packet ignored
        add_hdr();
        add_msg(8'h45, 31, 16'h0004, 64'h99, 1'b0, 32'd0, 32'd0);
        add_msg(8'h44, 19, 16'h0014, 64'hAB, 1'b0, 32'd0, 32'd0);
        send_packet(-1, 32);

        // Reset mid-packet: outputs clear, remainder of packet ignored
        add_hdr();
        add_msg(8'h44, 19, 16'h0021, 64'hC1, 1'b0, 32'd0, 32'd0);
        add_msg(8'h44, 19, 16'h0022, 64'hC2, 1'b0, 32'd0, 32'd0);
        add_msg(8'h44, 19, 16'h0023, 64'hC3, 1'b0, 32'd0, 32'd0);
        model(pkt.size());
        for (int i = 0; i < 30; i++) begin
            drive(pkt[i], 1'b1, 1'b0);
            check_cycle(i);
        end
        @(negedge clk);
        rstN = 1'b0;
        data = pkt[30];
        dataValid = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("midreset");
        evq.delete();
        exp_drop = 0;
        @(negedge clk);
        rstN = 1'b1;
        for (int i = 31; i < pkt.size(); i++) begin
            drive(pkt[i], 1'b1, 1'b0);
            check_cycle(i);
        end
        drive(8'h00, 1'b0, 1'b0);
        check_cycle(-1);
        chk("midreset_drop", 64'(msgDropCnt), 64'd0);
        pkt.delete();

        // Randomized packets
        for (int pk = 0; pk < 60; pk++) begin
            add_hdr();
            nm = $urandom_range(1, 4);
            for (int m = 0; m < nm; m++) begin
                r = $urandom_range(0, 9);
                if (r <= 2) begin
                    t = 8'h41;
                    len = ($urandom_range(0, 7) == 0) ? 35 + 2 * $urandom_range(0, 1) : 36;
                end else if (r <= 4) begin
                    t = 8'h44;
                    len = ($urandom_range(0, 7) == 0) ? 20 : 19;
                end else if (r <= 6) begin
                    t = 8'h45;
                    len = ($urandom_range(0, 7) == 0) ? 30 : 31;
                end else if (r == 7) begin
                    t = 8'h53;
                    len = 12;
                end else if (r == 8) begin
                    t = 8'h58;
                    len = $urandom_range(1, 40);
                end else begin
                    t = 8'h00;
                    len = 0;
                end
                add_msg(t, len, 16'($urandom), {32'($urandom), 32'($urandom)},
                        1'($urandom), 32'($urandom), 32'($urandom));
            end
            cut = -1;
            lost = -1;
            r = $urandom_range(0, 9);
            if (r < 2) cut = $urandom_range(1, pkt.size());
            else if (r < 4) lost = $urandom_range(0, pkt.size() - 1);
            send_packet(cut, lost);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
